// File: rtl/uart_rx_irq.sv
// uart_rx_irq: oversampling UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with show-ahead byte FIFO and IRQ.
// Revision 1.0 - initial release.
`default_nettype none

module uart_rx_irq #(
  parameter int DIV        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       uart_irq,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BW = $clog2(DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BCNT_MAX  = BW'(DIV - 1);
  localparam logic [BW-1:0] BCNT_HALF = BW'(DIV / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_d;

  logic          sync1, rxs;
  logic [BW-1:0] bcnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_err;
  logic          tick, mid;
  logic          stop_done, push_ok, bad_frame;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, pop, wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  assign tick = (bcnt == BCNT_MAX);
  assign mid  = (bcnt == BCNT_HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (!rxs) state_d = START;
      START: if (mid) state_d = rxs ? IDLE : DATA;
      DATA: begin
        if (tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // bcnt restarts on every state change and on every bit period inside a state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
    end else begin
      if (state_d != state || tick) bcnt <= '0;
      else                          bcnt <= bcnt + BW'(1);

      if (state == START && mid) begin
        bit_idx <= '0;
        par_err <= 1'b0;
      end
      if (state == DATA && tick) begin
        shreg   <= {rxs, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && tick) par_err <= ^{shreg, rxs};
`endif
    end
  end

  assign stop_done = (state == STOP) && tick;
  assign push_ok   = stop_done && rxs && !par_err;
  assign bad_frame = stop_done && (!rxs || par_err);

  assign empty = (wptr == rptr);
  assign full  = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
  assign pop   = rd_en && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign wr_en = push_ok && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= shreg;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_frame;
      overrun   <= push_ok && full && !pop;
    end
  end

  assign rd_data  = mem[rptr[AW-1:0]];
  assign rd_valid = !empty;
  assign uart_irq = !empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_irq.sv
// tb_uart_rx_irq: directed self-checking bench for uart_rx_irq (DIV=16, FIFO_DEPTH=4).
`default_nettype none

module tb_uart_rx_irq;

  localparam int DIV = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // frame-relative cycle whose following edge is the stop-sample edge
  localparam int STOP_IDX = 2 + DIV/2 + (NB-1)*DIV;

  logic       clk = 1'b0;
  logic       rst_n, rxd, rd_en;
  logic [7:0] rd_data;
  logic       rd_valid, uart_irq, frame_err, overrun;

  int checks = 0;
  int fails  = 0;
  int fe_hi = 0, fe_rise = 0, ov_hi = 0, ov_rise = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0;
  int fv;

  always #5 clk = ~clk;

  uart_rx_irq #(.DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .uart_irq(uart_irq),
    .frame_err(frame_err), .overrun(overrun)
  );

  always @(negedge clk) begin
    if (frame_err) fe_hi++;
    if (frame_err && !fe_prev) fe_rise++;
    if (overrun) ov_hi++;
    if (overrun && !ov_prev) ov_rise++;
    fe_prev = frame_err;
    ov_prev = overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; rd_en is raised for the cycle index pop_idx (-1 = never).
  task automatic send(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                      input int pop_idx, output int first_valid);
    logic [NB-1:0] fr;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = d;
`ifdef UART_RX_PARITY_EN
    fr[9] = (^d) ^ par_flip;
`endif
    fr[NB-1] = stop_bit;
    first_valid = -1;
    for (int i = 0; i < NB*DIV; i++) begin
      @(negedge clk);
      if (first_valid < 0 && rd_valid) first_valid = i;
      rxd   = fr[i/DIV];
      rd_en = (i == pop_idx);
    end
    @(negedge clk);
    rxd   = 1'b1;
    rd_en = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_data"}, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rxd = 1'b1; rd_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_irq", uart_irq, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_data", rd_data, 8'h00);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    chk("idle_fe", fe_hi, 0);
    chk("idle_ov", ov_hi, 0);
    chk("idle_valid", rd_valid, 0);

    // single byte and its arrival time
    send(8'hA5, 1'b1, 1'b0, -1, fv);
    chk("a5_time", fv, STOP_IDX + 1);
    chk("a5_data", rd_data, 8'hA5);
    chk("a5_irq", uart_irq, 1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("a5_pop_valid", rd_valid, 0);
    chk("a5_pop_irq", uart_irq, 0);

    // false start: 4 low cycles
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("false_valid", rd_valid, 0);
    chk("false_fe", fe_hi, 0);

    // stop bit low
    send(8'h3C, 1'b0, 1'b0, -1, fv);
    chk("ferr_rise", fe_rise, 1);
    chk("ferr_width", fe_hi, 1);
    chk("ferr_valid", rd_valid, 0);

    // overflow: fifth byte dropped
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 1'b1, 1'b0, -1, fv);
      if (b == 4) chk("ov_before", ov_rise, 0);
    end
    chk("ov_rise", ov_rise, 1);
    chk("ov_width", ov_hi, 1);
    for (int b = 1; b <= 4; b++) pop_check("ov_pop", 8'(b));
    @(negedge clk);
    chk("ov_empty", rd_valid, 0);

    // pointer wrap with reads in between
    for (int b = 0; b < 6; b++) begin
      send(8'h21 + 8'(b), 1'b1, 1'b0, -1, fv);
      pop_check("wrap", 8'h21 + 8'(b));
    end
    @(negedge clk);
    chk("wrap_empty", rd_valid, 0);

    // push and pop together while full
    for (int b = 0; b < 4; b++) send(8'h10 + 8'(b), 1'b1, 1'b0, -1, fv);
    send(8'h14, 1'b1, 1'b0, STOP_IDX, fv);
    chk("simul_no_ov", ov_rise, 1);
    for (int b = 1; b <= 4; b++) pop_check("simul_pop", 8'h10 + 8'(b));
    @(negedge clk);
    chk("simul_empty", rd_valid, 0);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1, -1, fv);
    chk("par_bad_fe", fe_rise, 2);
    chk("par_bad_valid", rd_valid, 0);
    send(8'h07, 1'b1, 1'b0, -1, fv);
    chk("par_ok_fe", fe_rise, 2);
    pop_check("par_ok", 8'h07);
`else
    chk("fe_total", fe_rise, 1);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

`default_nettype wire
